// File: rtl/data_path.sv
// 8-bit datapath: IR/MAR/PC/A/B/CCR registers, two bus muxes and an NZVC ALU.
// All registers share one synchronous active-high reset and a single rising-edge clock.
module data_path (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       IR_Load,
  input  logic       MAR_Load,
  input  logic       PC_Load,
  input  logic       PC_Inc,
  input  logic       A_Load,
  input  logic       B_Load,
  input  logic       CCR_Load,
  input  logic [2:0] ALU_Sel,
  input  logic [1:0] Bus1_Sel,
  input  logic [1:0] Bus2_Sel,
  input  logic [7:0] from_memory,
  output logic [7:0] IR,
  output logic [3:0] CCR_Result,
  output logic [7:0] address,
  output logic [7:0] to_memory
);

  logic [7:0] ir_q, ir_d;
  logic [7:0] mar_q, mar_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] ccr_q, ccr_d;

  logic [7:0] bus1;
  logic [7:0] bus2;
  logic [7:0] alu_r;
  logic [8:0] alu_wide;
  logic       alu_v;
  logic       alu_c;
  logic [3:0] alu_nzvc;

  always_comb begin
    unique case (Bus1_Sel)
      2'b00:   bus1 = pc_q;
      2'b01:   bus1 = a_q;
      2'b10:   bus1 = b_q;
      default: bus1 = 8'h00;
    endcase
  end

  // X = Bus1, Y = B. Bit 8 of the 9-bit result is carry for adds and borrow for subtracts.
  always_comb begin
    alu_wide = 9'h000;
    alu_r    = 8'h00;
    alu_v    = 1'b0;
    alu_c    = 1'b0;
    unique case (ALU_Sel)
      3'b000: begin
        alu_wide = {1'b0, bus1} + {1'b0, b_q};
        alu_r    = alu_wide[7:0];
        alu_c    = alu_wide[8];
        alu_v    = (bus1[7] == b_q[7]) && (alu_r[7] != bus1[7]);
      end
      3'b001: begin
        alu_wide = {1'b0, bus1} - {1'b0, b_q};
        alu_r    = alu_wide[7:0];
        alu_c    = alu_wide[8];
        alu_v    = (bus1[7] != b_q[7]) && (alu_r[7] != bus1[7]);
      end
      3'b010: alu_r = bus1 & b_q;
      3'b011: alu_r = bus1 | b_q;
      3'b100: begin
        alu_wide = {1'b0, bus1} + 9'd1;
        alu_r    = alu_wide[7:0];
        alu_c    = alu_wide[8];
        alu_v    = !bus1[7] && alu_r[7];
      end
      3'b101: begin
        alu_wide = {1'b0, bus1} - 9'd1;
        alu_r    = alu_wide[7:0];
        alu_c    = alu_wide[8];
        alu_v    = bus1[7] && !alu_r[7];
      end
      3'b110: alu_r = bus1 ^ b_q;
      default: alu_r = ~bus1;
    endcase
    alu_nzvc = {alu_r[7], (alu_r == 8'h00), alu_v, alu_c};
  end

  always_comb begin
    unique case (Bus2_Sel)
      2'b00:   bus2 = alu_r;
      2'b01:   bus2 = bus1;
      2'b10:   bus2 = from_memory;
      default: bus2 = 8'h00;
    endcase
  end

  always_comb begin
    ir_d  = IR_Load  ? bus2 : ir_q;
    mar_d = MAR_Load ? bus2 : mar_q;
    a_d   = A_Load   ? bus2 : a_q;
    b_d   = B_Load   ? bus2 : b_q;
    ccr_d = CCR_Load ? alu_nzvc : ccr_q;
    // A load wins over increment; increment wraps silently and never touches CCR.
    if (PC_Load) begin
      pc_d = bus2;
    end else if (PC_Inc) begin
      pc_d = pc_q + 8'd1;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ir_q  <= 8'h00;
      mar_q <= 8'h00;
      pc_q  <= 8'h00;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      ccr_q <= 4'h0;
    end else begin
      ir_q  <= ir_d;
      mar_q <= mar_d;
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      ccr_q <= ccr_d;
    end
  end

  assign IR         = ir_q;
  assign CCR_Result = ccr_q;
  assign address    = mar_q;
  assign to_memory  = bus1;

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: vector table through a scoreboard queue, plus a hand-driven fetch.
// Internal registers are observed through to_memory by steering Bus1 after each edge.
module tb_data_path;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic [7:0] from_memory;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic [7:0] address;
  logic [7:0] to_memory;

  logic [7:0] din_v;
  logic       use_mem;
  logic [7:0] mem [256];
  logic [7:0] mem_q;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] S_IR  = 7'b1000000;
  localparam logic [6:0] S_MAR = 7'b0100000;
  localparam logic [6:0] S_PCL = 7'b0010000;
  localparam logic [6:0] S_PCI = 7'b0001000;
  localparam logic [6:0] S_A   = 7'b0000100;
  localparam logic [6:0] S_B   = 7'b0000010;
  localparam logic [6:0] S_CCR = 7'b0000001;
  localparam logic [6:0] S_NO  = 7'b0000000;

  typedef struct {
    logic       rst;
    logic [1:0] b1;
    logic [1:0] b2;
    logic [2:0] alu;
    logic [6:0] strb;
    logic [7:0] din;
    logic [1:0] obs;
    logic [7:0] exp_tm;
    logic [7:0] exp_ir;
    logic [3:0] exp_ccr;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  data_path dut (
    .Clk(Clk), .Reset(Reset),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load),
    .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
    .from_memory(from_memory),
    .IR(IR), .CCR_Result(CCR_Result), .address(address), .to_memory(to_memory)
  );

  always #5 Clk = ~Clk;

  // Synchronous memory: read data appears the edge after the address.
  always_ff @(posedge Clk) mem_q <= mem[address];
  assign from_memory = use_mem ? mem_q : din_v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got 0x%02h, expected 0x%02h", name, idx, act, exp);
    end
  endtask

  task automatic idle_strobes();
    {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load} = S_NO;
    Reset = 1'b0;
  endtask

  task automatic add_vec(input logic rst, input logic [1:0] b1, input logic [1:0] b2,
                         input logic [2:0] alu, input logic [6:0] strb, input logic [7:0] din,
                         input logic [1:0] obs, input logic [7:0] tm, input logic [7:0] ir,
                         input logic [3:0] ccr, input logic [7:0] addr);
    vec_t v;
    v.rst = rst; v.b1 = b1; v.b2 = b2; v.alu = alu; v.strb = strb; v.din = din;
    v.obs = obs; v.exp_tm = tm; v.exp_ir = ir; v.exp_ccr = ccr; v.exp_addr = addr;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input int base);
    vec_t v, e;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      Reset    = v.rst;
      Bus1_Sel = v.b1;
      Bus2_Sel = v.b2;
      ALU_Sel  = v.alu;
      din_v    = v.din;
      {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load} = v.strb;
      exp_q.push_back(v);
      @(posedge Clk);
      #1;
      idle_strobes();
      Bus1_Sel = v.obs;
      #1;
      e = exp_q.pop_front();
      chk("to_memory", base + i, to_memory, e.exp_tm);
      chk("IR", base + i, IR, e.exp_ir);
      chk("CCR", base + i, {4'h0, CCR_Result}, {4'h0, e.exp_ccr});
      chk("address", base + i, address, e.exp_addr);
    end
    vecs.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h04] = 8'h86;
    use_mem = 1'b0;
    din_v = 8'h00;
    ALU_Sel = 3'b000;
    Bus1_Sel = 2'b00;
    Bus2_Sel = 2'b00;
    idle_strobes();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    chk("rst_IR", 0, IR, 8'h00);
    chk("rst_CCR", 0, {4'h0, CCR_Result}, 8'h00);
    chk("rst_address", 0, address, 8'h00);
    chk("rst_to_memory", 0, to_memory, 8'h00);

    // Preload every register, then reset while loads are asserted.
    //       rst  b1     b2     alu     strb                din    obs    tm     ir     ccr    addr
    add_vec(0, 2'b00, 2'b10, 3'd0, S_A,                8'h5A, 2'b01, 8'h5A, 8'h00, 4'h0, 8'h00);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_B,                8'h33, 2'b10, 8'h33, 8'h00, 4'h0, 8'h00);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_PCL,              8'h10, 2'b00, 8'h10, 8'h00, 4'h0, 8'h00);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_IR | S_MAR,       8'hC3, 2'b00, 8'h10, 8'hC3, 4'h0, 8'hC3);
    add_vec(0, 2'b01, 2'b00, 3'd0, S_CCR,              8'h00, 2'b01, 8'h5A, 8'hC3, 4'hA, 8'hC3);
    add_vec(1, 2'b00, 2'b10, 3'd0, S_A | S_IR | S_CCR, 8'h77, 2'b01, 8'h00, 8'h00, 4'h0, 8'h00);
    add_vec(0, 2'b00, 2'b00, 3'd0, S_NO,               8'h00, 2'b10, 8'h00, 8'h00, 4'h0, 8'h00);
    add_vec(0, 2'b00, 2'b00, 3'd0, S_NO,               8'h00, 2'b00, 8'h00, 8'h00, 4'h0, 8'h00);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_PCL,              8'h04, 2'b00, 8'h04, 8'h00, 4'h0, 8'h00);
    run_vecs(100);

    // Fetch: MAR <= PC, PC++, IR <= mem[MAR] (synchronous memory).
    use_mem = 1'b1;
    Bus1_Sel = 2'b00; Bus2_Sel = 2'b01; MAR_Load = 1'b1;
    @(posedge Clk); #1; idle_strobes(); #1;
    chk("fetch_mar", 0, address, 8'h04);
    PC_Inc = 1'b1;
    @(posedge Clk); #1; idle_strobes(); Bus1_Sel = 2'b00; #1;
    chk("fetch_pc", 1, to_memory, 8'h05);
    Bus2_Sel = 2'b10; IR_Load = 1'b1;
    @(posedge Clk); #1; idle_strobes(); #1;
    chk("fetch_ir", 2, IR, 8'h86);
    chk("fetch_addr", 2, address, 8'h04);
    chk("fetch_pc_hold", 2, to_memory, 8'h05);
    use_mem = 1'b0;

    //       rst  b1     b2     alu     strb           din    obs    tm     ir     ccr    addr
    add_vec(0, 2'b00, 2'b10, 3'd0, S_A,           8'h7F, 2'b01, 8'h7F, 8'h86, 4'h0, 8'h04);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_B,           8'h01, 2'b10, 8'h01, 8'h86, 4'h0, 8'h04);
    add_vec(0, 2'b01, 2'b00, 3'd0, S_A | S_CCR,   8'h00, 2'b01, 8'h80, 8'h86, 4'hA, 8'h04);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_A,           8'hFF, 2'b01, 8'hFF, 8'h86, 4'hA, 8'h04);
    add_vec(0, 2'b01, 2'b00, 3'd0, S_A | S_CCR,   8'h00, 2'b01, 8'h00, 8'h86, 4'h5, 8'h04);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_A,           8'h02, 2'b01, 8'h02, 8'h86, 4'h5, 8'h04);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_B,           8'h03, 2'b10, 8'h03, 8'h86, 4'h5, 8'h04);
    add_vec(0, 2'b01, 2'b00, 3'd1, S_A | S_CCR,   8'h00, 2'b01, 8'hFF, 8'h86, 4'h9, 8'h04);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_A,           8'h03, 2'b01, 8'h03, 8'h86, 4'h9, 8'h04);
    add_vec(0, 2'b01, 2'b00, 3'd1, S_A | S_CCR,   8'h00, 2'b01, 8'h00, 8'h86, 4'h4, 8'h04);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_B,           8'h0F, 2'b10, 8'h0F, 8'h86, 4'h4, 8'h04);
    add_vec(0, 2'b10, 2'b00, 3'd7, S_B | S_CCR,   8'h00, 2'b10, 8'hF0, 8'h86, 4'h8, 8'h04);
    add_vec(0, 2'b10, 2'b00, 3'd4, S_B | S_CCR,   8'h00, 2'b10, 8'hF1, 8'h86, 4'h8, 8'h04);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_A,           8'h80, 2'b01, 8'h80, 8'h86, 4'h8, 8'h04);
    add_vec(0, 2'b01, 2'b00, 3'd5, S_A | S_CCR,   8'h00, 2'b01, 8'h7F, 8'h86, 4'h2, 8'h04);
    add_vec(0, 2'b01, 2'b00, 3'd2, S_A | S_CCR,   8'h00, 2'b01, 8'h71, 8'h86, 4'h0, 8'h04);
    add_vec(0, 2'b01, 2'b00, 3'd6, S_A | S_CCR,   8'h00, 2'b01, 8'h80, 8'h86, 4'h8, 8'h04);
    add_vec(0, 2'b01, 2'b00, 3'd3, S_A | S_CCR,   8'h00, 2'b01, 8'hF1, 8'h86, 4'h8, 8'h04);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_A,           8'h00, 2'b01, 8'h00, 8'h86, 4'h8, 8'h04);
    add_vec(0, 2'b01, 2'b00, 3'd5, S_A | S_CCR,   8'h00, 2'b01, 8'hFF, 8'h86, 4'h9, 8'h04);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_A,           8'h7F, 2'b01, 8'h7F, 8'h86, 4'h9, 8'h04);
    add_vec(0, 2'b01, 2'b00, 3'd4, S_A | S_CCR,   8'h00, 2'b01, 8'h80, 8'h86, 4'hA, 8'h04);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_PCL,         8'hFF, 2'b00, 8'hFF, 8'h86, 4'hA, 8'h04);
    add_vec(0, 2'b00, 2'b00, 3'd0, S_PCI,         8'h00, 2'b00, 8'h00, 8'h86, 4'hA, 8'h04);
    add_vec(0, 2'b00, 2'b10, 3'd0, S_PCL | S_PCI, 8'h40, 2'b00, 8'h40, 8'h86, 4'hA, 8'h04);
    add_vec(0, 2'b00, 2'b01, 3'd0, S_A,           8'h99, 2'b01, 8'h40, 8'h86, 4'hA, 8'h04);
    add_vec(0, 2'b00, 2'b11, 3'd0, S_B,           8'h99, 2'b10, 8'h00, 8'h86, 4'hA, 8'h04);
    add_vec(0, 2'b00, 2'b00, 3'd0, S_NO,          8'h00, 2'b11, 8'h00, 8'h86, 4'hA, 8'h04);
    add_vec(0, 2'b00, 2'b00, 3'd0, S_NO,          8'h00, 2'b01, 8'h40, 8'h86, 4'hA, 8'h04);
    run_vecs(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
